// File: rtl/lbus_rx2axis.sv
// lbus_rx2axis: LBUS receive segment to AXI4-Stream bridge.
//
// Accepts one 128-bit LBUS segment per cycle and buffers it in a
// first-word-fall-through FIFO. On overflow, packets are truncated or
// dropped whole, so every beat that reaches the output belongs to a
// packet closed by tlast. mty on the closing beat becomes tkeep.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   lbus_rx_data/ena/sop/eop LBUS segment, start/end of packet
//   lbus_rx_err/mty          error flag and empty byte count (with eop)
//   m_axis_*                 AXI4-Stream master (tuser = packet error)
//   overflow                 sticky, set when any packet is cut or dropped
//   drop_cnt                 saturating count of cut or dropped packets
module lbus_rx2axis #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     lbus_rx_data,
  input  logic             lbus_rx_ena,
  input  logic             lbus_rx_sop,
  input  logic             lbus_rx_eop,
  input  logic             lbus_rx_err,
  input  logic [3:0]       lbus_rx_mty,
  output logic [127:0]     m_axis_tdata,
  output logic [15:0]      m_axis_tkeep,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   mty;
    logic         last;
    logic         user;
  } entry_t;

  function automatic logic [15:0] mty_to_keep(input logic [3:0] mty, input logic last);
    return last ? (16'hFFFF << mty) : 16'hFFFF;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t      state, state_nxt;
  entry_t      mem [DEPTH];
  entry_t      wr_entry, head;
  logic [AW:0] wptr, rptr, count, free;
  logic        wr, pop, drop;

  assign count = wptr - rptr;
  // Space is judged before this cycle's pop, so a pop never frees room
  // for a write in the same cycle.
  assign free  = DEPTH_L - count;
  assign pop   = m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_nxt     = state;
    wr            = 1'b0;
    drop          = 1'b0;
    wr_entry.data = lbus_rx_data;
    wr_entry.mty  = lbus_rx_mty;
    wr_entry.last = 1'b0;
    wr_entry.user = 1'b0;
    if (lbus_rx_ena) begin
      case (state)
        IDLE: begin
          if (!lbus_rx_sop) begin
            // Orphan beat: skip the rest of this fragment without counting it.
            if (!lbus_rx_eop) state_nxt = DROP;
          end else if (lbus_rx_eop) begin
            if (free >= (AW+1)'(1)) begin
              wr            = 1'b1;
              wr_entry.last = 1'b1;
              wr_entry.user = lbus_rx_err;
            end else begin
              drop = 1'b1;
            end
          end else if (free >= (AW+1)'(2)) begin
            // Two entries needed: this beat plus one kept for the closing beat.
            wr        = 1'b1;
            state_nxt = IN_PKT;
          end else begin
            drop      = 1'b1;
            state_nxt = DROP;
          end
        end
        IN_PKT: begin
          if (lbus_rx_eop) begin
            // The reserved entry guarantees room here.
            wr            = (free != '0);
            wr_entry.last = 1'b1;
            wr_entry.user = lbus_rx_err;
            state_nxt     = IDLE;
          end else if (free >= (AW+1)'(2)) begin
            wr = 1'b1;
          end else begin
            // Last free entry closes the packet as an errored, full beat.
            wr            = (free != '0);
            wr_entry.mty  = 4'd0;
            wr_entry.last = 1'b1;
            wr_entry.user = 1'b1;
            drop          = 1'b1;
            state_nxt     = DROP;
          end
        end
        DROP: begin
          if (lbus_rx_eop) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      wptr  <= wptr + {{AW{1'b0}}, wr};
      rptr  <= rptr + {{AW{1'b0}}, pop};
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= wr_entry;
  end

  // Outputs are forced to zero whenever the FIFO is empty, which also
  // covers reset, since the storage itself is never cleared.
  assign head          = mem[rptr[AW-1:0]];
  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head.data : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? mty_to_keep(head.mty, head.last) : '0;
  assign m_axis_tlast  = m_axis_tvalid && head.last;
  assign m_axis_tuser  = m_axis_tvalid && head.user;

endmodule
